bmp_copy_ctrl: RTL

BMP_COPY_CTRL -- requirements
Module: bmp_copy_ctrl

---
 rtl/bmp_copy_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/bmp_copy_ctrl.sv
// ROM->RAM byte copier for a BMP image. Each byte read is written one cycle later,
// and the width, height and pixel-data offset are captured from the header as it passes.
module bmp_copy_ctrl #(
   parameter int TOTAL_SIZE = 1078,
   parameter int ADDR_W     = 20,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic                  rom_valid,
   output logic [ADDR_W-1:0]     rom_addr,
   input  logic [BYTE_WIDTH-1:0] rom_data,
   output logic                  ram_valid,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [BYTE_WIDTH-1:0] ram_data,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W:0]       byte_count,
   output logic [31:0]           data_offset,
   output logic [31:0]           img_width,
   output logic [31:0]           img_height
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TOTAL_SIZE - 1);

   state_t     state;
   logic       aborted;
   logic [7:0] hdr_byte;

   // Gated so the data bus is quiet whenever no write is being issued, including in reset.
   assign ram_data = ram_valid ? rom_data : '0;
   assign hdr_byte = ram_data[7:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         aborted     <= 1'b0;
         rom_valid   <= 1'b0;
         rom_addr    <= '0;
         ram_valid   <= 1'b0;
         ram_addr    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         byte_count  <= '0;
         data_offset <= '0;
         img_width   <= '0;
         img_height  <= '0;
      end else begin
         // Header capture and write counting ride on the write stage.
         if (ram_valid) begin
            byte_count <= byte_count + 1'b1;
            for (int i = 0; i < 4; i++) begin
               if (ram_addr == ADDR_W'(10 + i)) data_offset[8*i +: 8] <= hdr_byte;
               if (ram_addr == ADDR_W'(18 + i)) img_width[8*i +: 8]   <= hdr_byte;
               if (ram_addr == ADDR_W'(22 + i)) img_height[8*i +: 8]  <= hdr_byte;
            end
         end

         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start && !abort) begin
                  state       <= READ;
                  aborted     <= 1'b0;
                  rom_valid   <= 1'b1;
                  rom_addr    <= '0;
                  busy        <= 1'b1;
                  byte_count  <= '0;
                  data_offset <= '0;
                  img_width   <= '0;
                  img_height  <= '0;
               end
            end
            READ: begin
               ram_valid <= 1'b1;
               ram_addr  <= rom_addr;
               if (abort || rom_addr == LAST) begin
                  state     <= DRAIN;
                  rom_valid <= 1'b0;
                  aborted   <= abort;
               end else begin
                  rom_addr <= rom_addr + 1'b1;
               end
            end
            DRAIN: begin
               ram_valid <= 1'b0;
               busy      <= 1'b0;
               if (aborted || abort) begin
                  state <= IDLE;
               end else begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
